layers_sched: RTL and testbench
===============================

LAYERS_SCHED -- requirements
Module: layers_sched

Interface
REQ-001 Parameter CFG_DWIDTH, default 32, configuration data width.
REQ-002 Parameter CFG_AWIDTH, default 5, configuration address width.
REQ-003 Parameter CFG_WIN_ADDR, default 6, config address for window/pool settings.
REQ-004 Parameter CFG_OUT_ADDR, default 7, config address for output count.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cfg_data, cfg_addr, cfg_valid  input  CFG_DWIDTH, CFG_AWIDTH, 1  shared configuration bus.
REQ-008 start, abort  input  1  single-cycle command strobes.
REQ-009 busy, done  output  1  busy = job active; done = one-cycle completion pulse.
REQ-010 src_val input 1, src_rdy output 1  image source handshake.
REQ-011 img_val output 1, img_last output 1, img_rdy input 1  handshake to the layers datapath image port.
REQ-012 res_val, res_rdy  input  1  observed result handshake of the layers datapath (monitor only).
REQ-013 out_cnt  output  16  number of results accepted in the current job.

Function
REQ-014 Config: cfg_valid & cfg_addr==CFG_WIN_ADDR loads win_len=cfg_data[15:0] and pool_nb=cfg_data[23:16]; cfg_valid & cfg_addr==CFG_OUT_ADDR loads out_nb=cfg_data[15:0].
REQ-015 Config writes while busy=1 shall be ignored; all other addresses ignored.
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; one state active at all times.
REQ-017 IDLE: start with win_len!=0 and out_nb!=0 -> RUN and clear beat_cnt, win_cnt, pix_cnt, res_cnt; start with either zero -> DONE; start is ignored in any other state.
REQ-018 RUN: img_val = src_val and src_rdy = img_rdy (combinational); in all other states img_val=0, src_rdy=0, img_last=0.
REQ-019 Beat fires when src_val & img_rdy in RUN; img_last=1 when beat_cnt==win_len-1.
REQ-020 On a fired beat, beat_cnt increments; on a fired last beat, beat_cnt resets to 0 and win_cnt increments, wrapping to 0 after pool_nb, when pix_cnt increments.
REQ-021 Final beat = last beat with win_cnt==pool_nb and pix_cnt==out_nb-1; it transitions RUN -> DRAIN; total beats issued = win_len*(pool_nb+1)*out_nb.
REQ-022 No beat fires while img_rdy=0 or src_val=0; counters hold.
REQ-023 res_cnt increments on res_val & res_rdy in RUN or DRAIN and saturates at out_nb; out_cnt = res_cnt.
REQ-024 DRAIN -> DONE when res_cnt==out_nb (including a result firing in the same cycle); results that arrived early during RUN are counted.
REQ-025 DONE lasts one cycle, done=1 in that cycle only, then IDLE.
REQ-026 busy=1 in RUN and DRAIN, registered from the state.
REQ-027 abort in RUN or DRAIN -> IDLE next cycle, counters cleared, no done pulse; abort takes priority over a simultaneous final beat or result; ignored in IDLE/DONE.
REQ-028 Simultaneous start and config write in IDLE: the job uses the pre-write config values; the write takes effect for the next job.

Reset
REQ-029 rst_n=0 shall immediately, without a clock edge, force IDLE, busy=0, done=0, img_val=0, img_last=0, src_rdy=0, out_cnt=0, all counters 0, win_len=0, pool_nb=0, out_nb=0.
REQ-030 Reset asserted mid-job shall abandon the job; after release a new start is required.

Verification
REQ-031 win_len=3, pool_nb=0, out_nb=2, src_val=img_rdy=1, start -> 6 beats, img_last on beats 3 and 6, DRAIN; 2 results -> done one cycle after the 2nd result fires, out_cnt=2.
REQ-032 win_len=2, pool_nb=1, out_nb=1 -> 4 beats, img_last on beats 2 and 4; 1 result -> done.
REQ-033 win_len=4, img_rdy toggling 1/0 each cycle -> exactly 4 beats over 8 cycles, src_rdy mirrors img_rdy, img_last only on the 4th fired beat.
REQ-034 out_nb=0, start -> done=1 on the following cycle, busy and img_val never 1.
REQ-035 abort after 2 beats of a 6-beat job -> IDLE next cycle, img_val=0; new start -> beat_cnt restarts at 0, full 6 beats issued.
REQ-036 rst_n low mid-RUN with no clock -> busy=0, img_val=0, out_cnt=0 immediately; cfg registers read back as 0 behaviour (start -> done, no beats).

Source files
------------

// File: rtl/layers_sched_if.sv
// layers_sched_if: bundles the configuration bus, job command/status,
// image source/sink handshakes and the result monitor of layers_sched.
//   slave  : scheduler side (layers_sched)
//   master : environment side (config host, source, datapath)
interface layers_sched_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5
) ();
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  src_val;
  logic                  src_rdy;
  logic                  img_val;
  logic                  img_last;
  logic                  img_rdy;
  logic                  res_val;
  logic                  res_rdy;
  logic [15:0]           out_cnt;

  modport slave (
    input  cfg_data, cfg_addr, cfg_valid, start, abort,
    input  src_val, img_rdy, res_val, res_rdy,
    output busy, done, src_rdy, img_val, img_last, out_cnt
  );

  modport master (
    output cfg_data, cfg_addr, cfg_valid, start, abort,
    output src_val, img_rdy, res_val, res_rdy,
    input  busy, done, src_rdy, img_val, img_last, out_cnt
  );
endinterface

// File: rtl/layers_sched.sv
// layers_sched: job scheduler for the layers datapath. Streams
// win_len*(pool_nb+1)*out_nb image beats from the source into the datapath
// (img_last closes each window), then waits until out_nb results were seen
// on the result handshake before pulsing done.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : layers_sched_if.slave (config bus, start/abort, busy/done,
//                src/img handshakes, result monitor, out_cnt)
module layers_sched #(
  parameter int CFG_DWIDTH   = 32,
  parameter int CFG_AWIDTH   = 5,
  parameter int CFG_WIN_ADDR = 6,
  parameter int CFG_OUT_ADDR = 7
) (
  input logic          clk,
  input logic          rst_n,
  layers_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] win_len_q, win_len_d;
  logic [7:0]  pool_nb_q, pool_nb_d;
  logic [15:0] out_nb_q, out_nb_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] res_cnt_q, res_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        run, fire, last, res_fire, cfg_we;
  logic        cfg_unused;

  // Upper config bits carry nothing for this block.
  assign cfg_unused = ^bus.cfg_data[CFG_DWIDTH-1:24];

  assign run      = (state_q == RUN);
  assign last     = (beat_cnt_q == win_len_q - 16'd1);
  assign fire     = run & bus.src_val & bus.img_rdy;
  assign res_fire = (run | (state_q == DRAIN)) & bus.res_val & bus.res_rdy;
  assign cfg_we   = bus.cfg_valid & ~busy_q;

  assign bus.img_val  = run & bus.src_val;
  assign bus.src_rdy  = run & bus.img_rdy;
  assign bus.img_last = run & last;
  assign bus.out_cnt  = res_cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    pool_nb_d  = pool_nb_q;
    out_nb_d   = out_nb_q;
    beat_cnt_d = beat_cnt_q;
    win_cnt_d  = win_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    res_cnt_d  = res_cnt_q;

    // A write landing with start only affects the next job: the job
    // decision below reads the _q values.
    if (cfg_we && bus.cfg_addr == CFG_AWIDTH'(CFG_WIN_ADDR)) begin
      win_len_d = bus.cfg_data[15:0];
      pool_nb_d = bus.cfg_data[23:16];
    end
    if (cfg_we && bus.cfg_addr == CFG_AWIDTH'(CFG_OUT_ADDR))
      out_nb_d = bus.cfg_data[15:0];

    // Early results (during RUN) count too; saturate at the expected total.
    if (res_fire && res_cnt_q < out_nb_q) res_cnt_d = res_cnt_q + 16'd1;

    unique case (state_q)
      IDLE: if (bus.start) begin
        beat_cnt_d = '0; win_cnt_d = '0; pix_cnt_d = '0; res_cnt_d = '0;
        state_d = (win_len_q != '0 && out_nb_q != '0) ? RUN : DONE;
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          beat_cnt_d = '0; win_cnt_d = '0; pix_cnt_d = '0; res_cnt_d = '0;
        end else if (fire) begin
          if (last) begin
            beat_cnt_d = '0;
            if (win_cnt_q == pool_nb_q) begin
              win_cnt_d = '0;
              pix_cnt_d = pix_cnt_q + 16'd1;
              if (pix_cnt_q == out_nb_q - 16'd1) state_d = DRAIN;
            end else begin
              win_cnt_d = win_cnt_q + 8'd1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
          beat_cnt_d = '0; win_cnt_d = '0; pix_cnt_d = '0; res_cnt_d = '0;
        end else if (res_cnt_d == out_nb_q) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      pool_nb_q  <= '0;
      out_nb_q   <= '0;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      res_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      pool_nb_q  <= pool_nb_d;
      out_nb_q   <= out_nb_d;
      beat_cnt_q <= beat_cnt_d;
      win_cnt_q  <= win_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      res_cnt_q  <= res_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_layers_sched.sv
// tb_layers_sched: directed vectors for layers_sched with hand-computed
// expectations; every comparison goes through chk().
module tb_layers_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  layers_sched_if #(.CFG_DWIDTH(32), .CFG_AWIDTH(5)) bus ();

  layers_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [31:0] d);
    bus.cfg_addr = a; bus.cfg_data = d; bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  // Runs ncyc cycles, counting fired beats, the beat indices carrying
  // img_last, done pulses, and (when toggling img_rdy) src_rdy mismatches.
  task automatic run_beats(input int ncyc, input bit tog, output int beats,
                           output int lmask, output int dones, output int rdy_mis);
    beats = 0; lmask = 0; dones = 0; rdy_mis = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (tog) bus.img_rdy = (i % 2 == 0);
      #1;
      if (tog && bus.busy && bus.src_rdy !== bus.img_rdy) rdy_mis++;
      if (bus.done) dones++;
      if (bus.img_val && bus.img_rdy) begin
        if (bus.img_last) lmask |= (1 << beats);
        beats++;
      end
      @(posedge clk); #1;
    end
  endtask

  int beats, lmask, dones, rmis;

  initial begin
    bus.cfg_data = '0; bus.cfg_addr = '0; bus.cfg_valid = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.src_val = 1'b0; bus.img_rdy = 1'b0;
    bus.res_val = 1'b0; bus.res_rdy = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_img_val", {31'd0, bus.img_val}, 0);
    chk("rst_src_rdy", {31'd0, bus.src_rdy}, 0);
    chk("rst_out_cnt", {16'd0, bus.out_cnt}, 0);
    tick(); rst_n = 1'b1; tick();

    // A: win 3, pool 0, out 2 -> 6 beats, last on beats 3 and 6
    cfg(5'd6, 32'h0000_0003);
    cfg(5'd7, 32'h0000_0002);
    bus.src_val = 1'b1; bus.img_rdy = 1'b1; bus.res_rdy = 1'b1;
    pulse_start();
    run_beats(10, 1'b0, beats, lmask, dones, rmis);
    chk("a_beats", beats, 6);
    chk("a_last", lmask, 32'h24);
    chk("a_drain_busy", {31'd0, bus.busy}, 1);
    chk("a_no_done", dones, 0);
    bus.res_val = 1'b1; tick();
    chk("a_res1_cnt", {16'd0, bus.out_cnt}, 1);
    chk("a_res1_done", {31'd0, bus.done}, 0);
    tick(); bus.res_val = 1'b0;
    chk("a_done", {31'd0, bus.done}, 1);
    chk("a_out_cnt", {16'd0, bus.out_cnt}, 2);
    tick();
    chk("a_done_1cyc", {31'd0, bus.done}, 0);
    chk("a_idle_busy", {31'd0, bus.busy}, 0);

    // B: win 2, pool 1, out 1 -> 4 beats, last on beats 2 and 4
    cfg(5'd6, 32'h0001_0002);
    cfg(5'd7, 32'h0000_0001);
    pulse_start();
    run_beats(10, 1'b0, beats, lmask, dones, rmis);
    chk("b_beats", beats, 4);
    chk("b_last", lmask, 32'ha);
    bus.res_val = 1'b1; tick(); bus.res_val = 1'b0;
    chk("b_done", {31'd0, bus.done}, 1);
    tick();

    // C: win 4, img_rdy toggling -> 4 beats in 8 cycles, then abort in DRAIN
    cfg(5'd6, 32'h0000_0004);
    pulse_start();
    run_beats(8, 1'b1, beats, lmask, dones, rmis);
    chk("c_beats", beats, 4);
    chk("c_last", lmask, 32'h8);
    chk("c_src_rdy", rmis, 0);
    chk("c_drain_busy", {31'd0, bus.busy}, 1);
    pulse_abort();
    chk("c_abort_busy", {31'd0, bus.busy}, 0);
    chk("c_abort_done", {31'd0, bus.done}, 0);
    tick();
    chk("c_abort_nodone", {31'd0, bus.done}, 0);
    bus.img_rdy = 1'b1;

    // D: out_nb 0 -> done next cycle, never busy, no beats
    cfg(5'd7, 32'h0000_0000);
    pulse_start();
    chk("d_done", {31'd0, bus.done}, 1);
    chk("d_busy", {31'd0, bus.busy}, 0);
    chk("d_img_val", {31'd0, bus.img_val}, 0);
    tick();
    chk("d_done_clr", {31'd0, bus.done}, 0);

    // F: config write while busy is dropped
    cfg(5'd6, 32'h0000_0001);
    cfg(5'd7, 32'h0000_0001);
    bus.src_val = 1'b0;
    pulse_start();
    cfg(5'd7, 32'h0000_0000);
    pulse_abort();
    pulse_start();
    chk("f_cfg_ignored", {31'd0, bus.busy}, 1);
    pulse_abort();

    // G: start together with a write uses the old config
    bus.cfg_addr = 5'd7; bus.cfg_data = 32'h0; bus.cfg_valid = 1'b1;
    bus.start = 1'b1; tick();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    chk("g_old_cfg", {31'd0, bus.busy}, 1);
    pulse_abort();
    pulse_start();
    chk("g_new_cfg", {31'd0, bus.done}, 1);
    tick();

    // E: abort after 2 of 6 beats, restart with early results held
    cfg(5'd6, 32'h0000_0003);
    cfg(5'd7, 32'h0000_0002);
    bus.src_val = 1'b1;
    pulse_start();
    run_beats(2, 1'b0, beats, lmask, dones, rmis);
    chk("e_pre_beats", beats, 2);
    pulse_abort();
    chk("e_abort_busy", {31'd0, bus.busy}, 0);
    chk("e_abort_imgval", {31'd0, bus.img_val}, 0);
    bus.res_val = 1'b1;
    pulse_start();
    run_beats(12, 1'b0, beats, lmask, dones, rmis);
    bus.res_val = 1'b0;
    chk("e_beats", beats, 6);
    chk("e_last", lmask, 32'h24);
    chk("e_dones", dones, 1);
    chk("e_out_sat", {16'd0, bus.out_cnt}, 2);

    // H: async reset mid-RUN
    bus.res_val = 1'b1;
    pulse_start();
    run_beats(2, 1'b0, beats, lmask, dones, rmis);
    chk("h_pre_cnt", {16'd0, bus.out_cnt}, 2);
    chk("h_pre_busy", {31'd0, bus.busy}, 1);
    rst_n = 1'b0; #1;
    chk("h_busy", {31'd0, bus.busy}, 0);
    chk("h_img_val", {31'd0, bus.img_val}, 0);
    chk("h_src_rdy", {31'd0, bus.src_rdy}, 0);
    chk("h_out_cnt", {16'd0, bus.out_cnt}, 0);
    bus.res_val = 1'b0;
    tick(); rst_n = 1'b1; tick();
    pulse_start();
    chk("h_cfg_zero_done", {31'd0, bus.done}, 1);
    chk("h_cfg_zero_busy", {31'd0, bus.busy}, 0);
    chk("h_cfg_zero_img", {31'd0, bus.img_val}, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
